// File: rtl/operand_hit_detector.sv
// operand_hit_detector
//   Turns pixel-level overlap between the player sprite and the two operand
//   sprites into exactly one hit pulse per contact. Overlap is accumulated over
//   a frame and judged at the next startOfFrame. After a hit, the operand
//   ignores further contact for COOLDOWN_FRAMES frames. The player must then
//   leave the operand for one full frame before the operand can be hit again.
//
// Ports
//   clk           system clock
//   resetN        synchronous reset, active HIGH despite the name
//   startOfFrame  one-cycle frame-start pulse from the VGA controller
//   playerDR      player drawing request for the current pixel
//   operandDR     per-operand drawing request (bit 0 plus, bit 1 minus)
//   singleHit     one-cycle hit pulse per operand, the cycle after evaluation
//   hitCount      saturating hit count per operand ([j] is operand j)
//   armed         operand FSM is in IDLE and a hit would be accepted
//
// Handshake: there is no back-pressure. A pulse on singleHit[j] is valid for
// exactly one clk and must be consumed in that cycle. hitCount[j] already
// includes that hit in the same cycle.
module operand_hit_detector #(
  parameter int unsigned COOLDOWN_FRAMES = 450,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  playerDR,
  input  logic [1:0]            operandDR,
  output logic [1:0]            singleHit,
  output logic [1:0][CNT_W-1:0] hitCount,
  output logic [1:0]            armed
);

  // Counter wide enough to hold COOLDOWN_FRAMES. A value of 0 is not supported.
  localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_COOLDOWN     = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_e;

  state_e            state_q [2];
  state_e            state_d [2];
  logic [CD_W-1:0]   cnt_q   [2];
  logic [CD_W-1:0]   cnt_d   [2];
  logic [1:0]        cf_q, cf_d;
  logic [1:0]        hit_q, hit_d;
  logic [1:0]        armed_q, armed_d;
  logic [1:0][CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic [1:0] overlap;
  logic [1:0] frame_hit;

  assign overlap   = {2{playerDR}} & operandDR;
  // An overlap in the startOfFrame cycle still belongs to the ending frame.
  assign frame_hit = cf_q | overlap;

  // Contact flags. At a frame boundary the flag restarts from this cycle's
  // overlap, so a startOfFrame-cycle overlap counts in both frames.
  always_comb begin
    cf_d = cf_q | overlap;
    if (startOfFrame) begin
      cf_d = overlap;
    end
  end

  // Next-state logic. Each FSM moves only on startOfFrame.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      state_d[j] = state_q[j];
      cnt_d[j]   = cnt_q[j];
      if (startOfFrame) begin
        case (state_q[j])
          ST_IDLE: begin
            if (frame_hit[j]) begin
              state_d[j] = ST_COOLDOWN;
              cnt_d[j]   = CD_LOAD;
            end
          end
          ST_COOLDOWN: begin
            cnt_d[j] = cnt_q[j] - CD_ONE;
            if (cnt_q[j] == CD_ONE) begin
              state_d[j] = ST_WAIT_RELEASE;
            end
          end
          ST_WAIT_RELEASE: begin
            if (!frame_hit[j]) begin
              state_d[j] = ST_IDLE;
            end
          end
          default: begin
            state_d[j] = ST_IDLE;
            cnt_d[j]   = '0;
          end
        endcase
      end
    end
  end

  // Output logic: pulse, saturating count and armed flag, all registered.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      hit_d[j]     = startOfFrame && (state_q[j] == ST_IDLE) && frame_hit[j];
      hit_cnt_d[j] = hit_cnt_q[j];
      if (hit_d[j] && (hit_cnt_q[j] != {CNT_W{1'b1}})) begin
        hit_cnt_d[j] = hit_cnt_q[j] + CNT_W'(1);
      end
      armed_d[j] = (state_d[j] == ST_IDLE);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (resetN) begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= ST_IDLE;
        cnt_q[j]   <= '0;
      end
      cf_q      <= '0;
      hit_q     <= '0;
      armed_q   <= 2'b11;
      hit_cnt_q <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= state_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
      cf_q      <= cf_d;
      hit_q     <= hit_d;
      armed_q   <= armed_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign singleHit = hit_q;
  assign hitCount  = hit_cnt_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_operand_hit_detector.sv
// Bench for operand_hit_detector. Two instances share one stimulus stream:
// dut_a uses the default cooldown (450 frames, 8-bit counters) and dut_b uses
// a cooldown of 1 frame with 2-bit counters, so counter saturation can be
// reached. The reference model works per frame. It remembers when each operand
// was last hit and whether a clean release frame has been seen since then.
module tb_operand_hit_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN;
  logic       startOfFrame;
  logic       playerDR;
  logic [1:0] operandDR;

  logic [1:0]      hit_a, arm_a, hit_b, arm_b;
  logic [1:0][7:0] cnt_a;
  logic [1:0][1:0] cnt_b;

  operand_hit_detector #(.COOLDOWN_FRAMES(450), .CNT_W(8)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .playerDR(playerDR), .operandDR(operandDR),
    .singleHit(hit_a), .hitCount(cnt_a), .armed(arm_a));

  operand_hit_detector #(.COOLDOWN_FRAMES(1), .CNT_W(2)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .playerDR(playerDR), .operandDR(operandDR),
    .singleHit(hit_b), .hitCount(cnt_b), .armed(arm_b));

  // ---------------- scoreboard ----------------
  // Entry layout: [19:18] singleHit, [17:2] hitCount (zero-extended), [1:0] armed
  logic [19:0] exp_a_q[$];
  logic [19:0] exp_b_q[$];
  int compared   = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  int   cd_frames[2] = '{450, 1};
  int   cnt_max[2]   = '{255, 3};
  logic [1:0] cf_m;
  bit   has_hit[2][2];
  bit   released[2][2];
  int   hit_eval[2][2];
  int   cnt_m[2][2];
  bit   pulse_m[2][2];
  int   eval_idx = 0;

  function automatic bit idle_m(int d, int j);
    return !has_hit[d][j] || released[d][j];
  endfunction

  task automatic model_step(input bit sof, input bit pl, input logic [1:0] op, input bit rst);
    logic [1:0] ov;
    bit fh;
    ov = pl ? op : 2'b00;
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < 2; j++) pulse_m[d][j] = 1'b0;
    if (rst) begin
      cf_m = 2'b00;
      for (int d = 0; d < 2; d++)
        for (int j = 0; j < 2; j++) begin
          has_hit[d][j] = 1'b0; released[d][j] = 1'b0; cnt_m[d][j] = 0;
        end
    end else if (sof) begin
      eval_idx++;
      for (int d = 0; d < 2; d++)
        for (int j = 0; j < 2; j++) begin
          fh = cf_m[j] | ov[j];
          if (idle_m(d, j)) begin
            if (fh) begin
              has_hit[d][j]  = 1'b1;
              released[d][j] = 1'b0;
              hit_eval[d][j] = eval_idx;
              pulse_m[d][j]  = 1'b1;
              if (cnt_m[d][j] < cnt_max[d]) cnt_m[d][j]++;
            end
          end else if ((eval_idx > hit_eval[d][j] + cd_frames[d]) && !fh) begin
            released[d][j] = 1'b1;
          end
        end
      cf_m = ov;
    end else begin
      cf_m = cf_m | ov;
    end
  endtask

  function automatic logic [19:0] pack_exp(int d);
    logic [15:0] c;
    if (d == 0) c = {8'(cnt_m[0][1]), 8'(cnt_m[0][0])};
    else        c = {12'd0, 2'(cnt_m[1][1]), 2'(cnt_m[1][0])};
    return {pulse_m[d][1], pulse_m[d][0], c, idle_m(d, 1), idle_m(d, 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit sof, input bit pl, input logic [1:0] op, input bit rst);
    @(negedge clk);
    resetN       = rst;
    startOfFrame = sof;
    playerDR     = pl;
    operandDR    = op;
    model_step(sof, pl, op, rst);
    exp_a_q.push_back(pack_exp(0));
    exp_b_q.push_back(pack_exp(1));
  endtask

  // A cycle where player and operands may be drawn but never overlap.
  task automatic quiet_cyc(input bit sof);
    bit pl;
    pl = bit'($urandom_range(0, 1));
    cyc(sof, pl, pl ? 2'b00 : 2'($urandom_range(0, 3)), 1'b0);
  endtask

  // One frame of len cycles. op_ov overlaps for n_ov consecutive pixels, and
  // sof_ov also makes the startOfFrame cycle itself an overlap.
  task automatic frame(input int len, input logic [1:0] op_ov, input int n_ov, input bit sof_ov);
    int start;
    if (n_ov > len - 1) n_ov = len - 1;
    start = $urandom_range(1, len - n_ov);
    if (sof_ov) cyc(1'b1, 1'b1, op_ov, 1'b0);
    else        quiet_cyc(1'b1);
    for (int i = 1; i < len; i++) begin
      if (i >= start && i < start + n_ov) cyc(1'b0, 1'b1, op_ov, 1'b0);
      else                                quiet_cyc(1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string nm, input logic [19:0] exp, input logic [19:0] act);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t: got hit=%b cnt=%h armed=%b, expected hit=%b cnt=%h armed=%b",
               nm, $time, act[19:18], act[17:2], act[1:0], exp[19:18], exp[17:2], exp[1:0]);
    end
  endtask

  logic [19:0] mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_a_q.size() > 0) begin
      mon_e = exp_a_q.pop_front();
      check("dut_a", mon_e, {hit_a, cnt_a, arm_a});
    end
    if (exp_b_q.size() > 0) begin
      mon_e = exp_b_q.pop_front();
      check("dut_b", mon_e, {hit_b, 12'd0, cnt_b, arm_b});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; playerDR = 1'b0; operandDR = 2'b00;
    cf_m = 2'b00;
    do_reset(2);

    // Short contact on operand 0, evaluated at the next frame start.
    frame(6, 2'b00, 0, 1'b0);
    frame(6, 2'b01, 3, 1'b0);
    repeat (3) frame(6, 2'b00, 0, 1'b0);

    // Continuous contact for 500 frames, then one clean frame and contact again.
    for (int f = 0; f < 500; f++) frame(6, 2'b01, $urandom_range(1, 4), 1'b0);
    frame(6, 2'b00, 0, 1'b0);
    frame(6, 2'b01, 2, 1'b0);
    frame(6, 2'b00, 0, 1'b0);

    // Reset in the middle of cooldown, with the contact flag set.
    for (int f = 0; f < 250; f++) frame(6, 2'b01, $urandom_range(0, 2), 1'b0);
    quiet_cyc(1'b1);
    cyc(1'b0, 1'b1, 2'b01, 1'b0);
    do_reset(1);
    repeat (3) quiet_cyc(1'b0);

    // Fresh contact on both operands in the same frame.
    frame(6, 2'b11, 3, 1'b0);
    repeat (2) frame(6, 2'b00, 0, 1'b0);

    // Overlap only in the startOfFrame cycle.
    do_reset(1);
    frame(6, 2'b00, 0, 1'b0);
    frame(6, 2'b01, 0, 1'b1);
    repeat (3) frame(6, 2'b00, 0, 1'b0);

    // Five separate contacts with release frames between them.
    do_reset(1);
    for (int h = 0; h < 5; h++) begin
      frame(6, 2'b01, 2, 1'b0);
      repeat (3) frame(6, 2'b00, 0, 1'b0);
    end

    // Random frames with occasional resets.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 39) == 0) do_reset(1);
      frame($urandom_range(3, 10), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 7) == 0);
    end

    repeat (3) quiet_cyc(1'b0);
    repeat (2) @(negedge clk);

    compared++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0",
               exp_a_q.size(), exp_b_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_hit_detector.md
Name: operand_hit_detector

Overview:
- Collision-side producer of the two-bit single-hit vector consumed by the operand display block (bit 0 = plus operand, bit 1 = minus operand).
- Monitors the player drawing request against each operand drawing request pixel-by-pixel, accumulates overlap per frame, and evaluates once per frame.
- Emits a one-cycle hit pulse per operand, then enforces a frame-counted cooldown and a release condition so one contact yields exactly one hit.
- Also keeps a saturating hit count per operand for the scoring logic.

Parameters:
- COOLDOWN_FRAMES, 450, frames during which a further hit on the same operand is ignored; matches the display hide time.
- CNT_W, 8, width of each per-operand hit counter.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
- startOfFrame  in  1  one-cycle pulse from the VGA controller at frame start.
- playerDR  in  1  player sprite drawing request for the current pixel.
- operandDR  in  2  per-operand drawing request for the current pixel.
- singleHit  out  2  one-cycle hit pulse per operand.
- hitCount  out  2xCNT_W  saturating hits per operand.
- armed  out  2  operand is in IDLE and can register a hit (debug/scoring gate).

Behaviour:
- Reset (resetN=1): singleHit=0, hitCount=0, armed=2'b11; contact flags cleared; all FSMs in IDLE; cooldown counters 0. Reset mid-frame discards partial contact and any pending pulse.
- Contact flag cf[j]: set in any cycle with playerDR && operandDR[j]; held until frame evaluation.
- Frame evaluation occurs in the startOfFrame cycle: fh[j] = cf[j], or the overlap in this same cycle. Then cf[j] is cleared, except that an overlap in the startOfFrame cycle also sets cf[j] for the new frame (counts in both frames).
- Per-operand FSM, advancing only on startOfFrame:
  - IDLE: if fh[j], go to COOLDOWN, load cnt[j]=COOLDOWN_FRAMES, and issue the pulse.
  - COOLDOWN: decrement cnt[j]. When the decrement reaches 0, go to WAIT_RELEASE. A fh[j] here is ignored.
  - WAIT_RELEASE: if !fh[j], go to IDLE. Otherwise stay; the player is still overlapping the reappeared operand.
- Pulse timing: singleHit[j]=1 for exactly one clk, the cycle after the evaluating startOfFrame (registered). At most one pulse per operand per frame.
- Both operands are independent. A simultaneous hit on both gives singleHit=2'b11 in the same cycle.
- hitCount[j] increments in the same cycle singleHit[j] is asserted and saturates at 2^CNT_W-1 (no wrap).
- armed[j] = (state==IDLE), registered.
- COOLDOWN_FRAMES=0 is illegal. Minimum supported is 1 (IDLE to COOLDOWN to WAIT_RELEASE over 2 frames).
- Latency from contact pixel to pulse: at most 1 frame + 1 cycle.

Test Plan:
- Reset then overlap on operand 0 for 3 pixels in frame N -> singleHit=2'b01 for one cycle after frame N+1 startOfFrame; hitCount[0]=1; armed[0]=0.
- Keep the player overlapping operand 0 for 500 frames (COOLDOWN_FRAMES=450) -> exactly one pulse; state holds in WAIT_RELEASE after frame 451; release for one frame and re-overlap -> second pulse, hitCount[0]=2.
- Overlap both operands in the same frame -> singleHit=2'b11 in one cycle; both counters become 1.
- Overlap only in the startOfFrame cycle -> hit counted for the ending frame; cf set for the new frame. The new-frame flag is ignored because the FSM is already in COOLDOWN.
- CNT_W=2, 5 separate hits with COOLDOWN_FRAMES=1 and releases between them -> hitCount saturates at 3; 5 pulses observed.
- Assert resetN during COOLDOWN with cnt=200 and cf set -> next cycle: outputs at reset values, armed=2'b11; a fresh overlap produces a hit one frame later.
